// File: rtl/jolt_pkg.sv
// Shared types and constants for the jolt-finding datapath.
// Used by the bank loader and the downstream finder.
package jolt_pkg;

  localparam int BANK_DIGITS = 5;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_HOLD,
    ST_DISCARD
  } bank_ld_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BADCHAR = 2'd1,
    ERR_LONG    = 2'd2,
    ERR_SHORT   = 2'd3
  } bank_err_t;

endpackage

// File: rtl/bank_loader.sv
// ASCII line parser: packs one bank of digits into a BCD word.
// BANK_LOADER_ERR_CNT_EN adds a saturating rejected-line counter.
module bank_loader
  import jolt_pkg::*;
#(
  parameter int DIGITS    = BANK_DIGITS,
  parameter int ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ch_valid,
  input  logic [7:0]            ch_data,
  output logic                  ch_ready,
  output logic                  bank_valid,
  output logic [4*DIGITS-1:0]   bank_data,
  input  logic                  bank_ready,
  output logic                  err_pulse,
`ifdef BANK_LOADER_ERR_CNT_EN
  output logic [1:0]            err_code,
  output logic [ERR_CNT_W-1:0]  err_count
`else
  output logic [1:0]            err_code
`endif
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int DW = 4 * DIGITS;

  bank_ld_state_t state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [DW-1:0]  sr, sr_n;
  logic           pulse_q, pulse_n;
  bank_err_t      code_q, code_n;
  logic           acc;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

  assign acc        = ch_valid && ch_ready;
  assign ch_ready   = (state != ST_HOLD);
  assign bank_valid = (state == ST_HOLD);
  assign bank_data  = sr;
  assign err_pulse  = pulse_q;
  assign err_code   = code_q;

  // State, digit count, shift register and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_COLLECT;
      cnt     <= '0;
      sr      <= '0;
      pulse_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sr      <= sr_n;
      pulse_q <= pulse_n;
      code_q  <= code_n;
    end
  end

  // Per-byte line parsing and output handshake.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    pulse_n = 1'b0;
    code_n  = code_q;
    unique case (state)
      ST_COLLECT: begin
        if (acc) begin
          unique case (1'b1)
            is_digit(ch_data): begin
              if (cnt < CW'(DIGITS)) begin
                sr_n  = (sr << 4) | DW'(ch_data[3:0]);
                cnt_n = cnt + CW'(1);
              end else begin
                pulse_n = 1'b1;
                code_n  = ERR_LONG;
                state_n = ST_DISCARD;
              end
            end
            (ch_data == ASCII_CR): begin
              state_n = ST_COLLECT;
            end
            (ch_data == ASCII_LF): begin
              if (cnt == CW'(DIGITS)) begin
                state_n = ST_HOLD;
              end else if (cnt != '0) begin
                pulse_n = 1'b1;
                code_n  = ERR_SHORT;
                cnt_n   = '0;
                sr_n    = '0;
              end
            end
            default: begin
              pulse_n = 1'b1;
              code_n  = ERR_BADCHAR;
              state_n = ST_DISCARD;
            end
          endcase
        end
      end
      ST_HOLD: begin
        if (bank_ready) begin
          cnt_n   = '0;
          state_n = ST_COLLECT;
        end
      end
      ST_DISCARD: begin
        if (acc && (ch_data == ASCII_LF)) begin
          cnt_n   = '0;
          state_n = ST_COLLECT;
        end
      end
      default: begin
        state_n = ST_COLLECT;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef BANK_LOADER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] ecnt;

  assign err_count = ecnt;

  // Rejected-line counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt <= '0;
    end else if (pulse_q && !(&ecnt)) begin
      ecnt <= ecnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bank_loader.sv
// Self-checking bench for bank_loader.
// Reference model works per text line from the parsing rules.
module tb_bank_loader;
  import jolt_pkg::*;

  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ch_valid;
  logic [7:0]   ch_data;
  logic         ch_ready;
  logic         bank_valid;
  logic [4*D-1:0] bank_data;
  logic         bank_ready;
  logic         err_pulse;
  logic [1:0]   err_code;
`ifdef BANK_LOADER_ERR_CNT_EN
  logic [7:0]   err_count;
`endif

  int total = 0;
  int bad   = 0;
  int err_model = 0;
  bit done;

  logic [4*D-1:0] exp_banks[$];
  logic [4*D-1:0] obs_banks[$];
  logic [1:0]     exp_errs[$];
  logic [1:0]     obs_errs[$];

  always #5 clk = ~clk;

  bank_loader #(.DIGITS(D), .ERR_CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch_valid(ch_valid),
    .ch_data(ch_data),
    .ch_ready(ch_ready),
    .bank_valid(bank_valid),
    .bank_data(bank_data),
    .bank_ready(bank_ready),
    .err_pulse(err_pulse),
`ifdef BANK_LOADER_ERR_CNT_EN
    .err_code(err_code),
    .err_count(err_count)
`else
    .err_code(err_code)
`endif
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (bank_valid && bank_ready) obs_banks.push_back(bank_data);
      if (err_pulse) obs_errs.push_back(err_code);
    end
  end

  function automatic void model_line(input string s);
    int n = 0;
    int e = 0;
    longint w = 0;
    for (int i = 0; i < s.len(); i++) begin
      byte c = s[i];
      if (c >= "0" && c <= "9") begin
        if (n < D) begin
          w = (w * 16 + (c - "0")) % (64'd1 << (4 * D));
          n++;
        end else begin
          e = 2;
          break;
        end
      end else if (c != 8'h0D) begin
        e = 1;
        break;
      end
    end
    if (e == 0 && n == D) exp_banks.push_back(w[4*D-1:0]);
    else if (e == 0 && n != 0) e = 3;
    if (e != 0) begin
      exp_errs.push_back(e[1:0]);
      err_model++;
    end
  endfunction

  task automatic send_byte(input logic [7:0] c);
    int t = 0;
    ch_data  = c;
    ch_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ch_ready) break;
      t++;
      if (t > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout byte=%h ch_ready stuck 0", c);
        ch_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(8'h0A);
    model_line(s);
  endtask

  task automatic drain();
    bank_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_banks.delete();
    obs_banks.delete();
    exp_errs.delete();
    obs_errs.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_valid = 1'b0;
    ch_data = 8'h00;
    bank_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bank_valid !== 1'b0 || bank_data !== '0 || err_pulse !== 1'b0 ||
        err_code !== 2'd0 || ch_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got v=%b d=%h p=%b c=%0d r=%b want 0 0 0 0 1",
               bank_valid, bank_data, err_pulse, err_code, ch_ready);
    end
`ifdef BANK_LOADER_ERR_CNT_EN
    total++;
    if (err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_errcnt got %0d want 0", err_count);
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    err_model = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_q();
    bank_ready = 1'b1;
    send_line("98765");
    @(negedge clk);
    total++;
    if (bank_valid !== 1'b1 || bank_data !== 20'h98765 || ch_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold got v=%b d=%h r=%b want 1 98765 0",
               bank_valid, bank_data, ch_ready);
    end
    @(negedge clk);
    total++;
    if (bank_valid !== 1'b0 || ch_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_release got v=%b r=%b want 0 1", bank_valid, ch_ready);
    end
    drain();
    total++;
    if (obs_banks.size() != 1 || obs_errs.size() != 0) begin
      bad++;
      $display("FAIL basic_count got banks=%0d errs=%0d want 1 0",
               obs_banks.size(), obs_errs.size());
    end
  endtask

  task automatic test_backpressure();
    int bp_bad = 0;
    clear_q();
    bank_ready = 1'b0;
    send_line("12345\r");
    repeat (10) begin
      @(negedge clk);
      if (bank_valid !== 1'b1 || bank_data !== 20'h12345 || ch_ready !== 1'b0)
        bp_bad++;
    end
    total++;
    if (bp_bad != 0) begin
      bad++;
      $display("FAIL bp_hold got %0d bad cycles want 0", bp_bad);
    end
    bank_ready = 1'b1;
    send_line("54321");
    drain();
    total++;
    if (obs_banks.size() != 2) begin
      bad++;
      $display("FAIL bp_count got %0d want 2", obs_banks.size());
    end else begin
      total++;
      if (obs_banks[0] !== 20'h12345 || obs_banks[1] !== 20'h54321) begin
        bad++;
        $display("FAIL bp_data got %h %h want 12345 54321",
                 obs_banks[0], obs_banks[1]);
      end
    end
  endtask

  task automatic test_errors();
    clear_q();
    bank_ready = 1'b1;
    send_line("12a45");
    send_line("11111");
    send_line("123456");
    send_line("123");
    send_line("");
    drain();
    total++;
    if (obs_errs.size() != 3 || obs_banks.size() != 1) begin
      bad++;
      $display("FAIL err_count got errs=%0d banks=%0d want 3 1",
               obs_errs.size(), obs_banks.size());
    end else begin
      total++;
      if (obs_errs[0] !== 2'd1 || obs_errs[1] !== 2'd2 || obs_errs[2] !== 2'd3) begin
        bad++;
        $display("FAIL err_codes got %0d %0d %0d want 1 2 3",
                 obs_errs[0], obs_errs[1], obs_errs[2]);
      end
      total++;
      if (obs_banks[0] !== 20'h11111) begin
        bad++;
        $display("FAIL err_good got %h want 11111", obs_banks[0]);
      end
    end
    total++;
    if (err_code !== 2'd3 || err_pulse !== 1'b0) begin
      bad++;
      $display("FAIL err_hold got c=%0d p=%b want 3 0", err_code, err_pulse);
    end
  endtask

  task automatic test_random();
    string badc = "ab x-,:/Z";
    clear_q();
    done = 1'b0;
    fork
      begin
        for (int l = 0; l < 60; l++) begin
          string s = "";
          int kind = $urandom_range(0, 5);
          int n = (kind == 2) ? $urandom_range(1, 4) :
                  (kind == 3) ? $urandom_range(6, 8) :
                  (kind == 5) ? 0 : D;
          for (int i = 0; i < n; i++)
            s = $sformatf("%s%c", s, 8'h30 + $urandom_range(0, 9));
          if (kind == 4) begin
            int p = $urandom_range(0, D - 1);
            s[p] = badc[$urandom_range(0, badc.len() - 1)];
          end
          if ($urandom_range(0, 3) == 0) s = $sformatf("%s%c", s, 8'h0D);
          send_line(s);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bank_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    total++;
    if (obs_banks.size() != exp_banks.size()) begin
      bad++;
      $display("FAIL rnd_banks got %0d want %0d", obs_banks.size(), exp_banks.size());
    end else begin
      foreach (exp_banks[i]) begin
        total++;
        if (obs_banks[i] !== exp_banks[i]) begin
          bad++;
          $display("FAIL rnd_bank[%0d] got %h want %h", i, obs_banks[i], exp_banks[i]);
        end
      end
    end
    total++;
    if (obs_errs.size() != exp_errs.size()) begin
      bad++;
      $display("FAIL rnd_errs got %0d want %0d", obs_errs.size(), exp_errs.size());
    end else begin
      foreach (exp_errs[i]) begin
        total++;
        if (obs_errs[i] !== exp_errs[i]) begin
          bad++;
          $display("FAIL rnd_err[%0d] got %0d want %0d", i, obs_errs[i], exp_errs[i]);
        end
      end
    end
`ifdef BANK_LOADER_ERR_CNT_EN
    total++;
    if (int'(err_count) != ((err_model > 255) ? 255 : err_model)) begin
      bad++;
      $display("FAIL rnd_errcnt got %0d want %0d", err_count, err_model);
    end
`endif
  endtask

  task automatic test_midline_reset();
    clear_q();
    bank_ready = 1'b1;
    send_byte("9");
    send_byte("8");
    send_byte("7");
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (bank_valid !== 1'b0 || bank_data !== '0 || err_code !== 2'd0 ||
        ch_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset got v=%b d=%h c=%0d r=%b want 0 0 0 1",
               bank_valid, bank_data, err_code, ch_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    err_model = 0;
    send_line("11111");
    drain();
    total++;
    if (obs_banks.size() != 1 || obs_errs.size() != 0) begin
      bad++;
      $display("FAIL mid_count got banks=%0d errs=%0d want 1 0",
               obs_banks.size(), obs_errs.size());
    end else begin
      total++;
      if (obs_banks[0] !== 20'h11111) begin
        bad++;
        $display("FAIL mid_data got %h want 11111", obs_banks[0]);
      end
    end
`ifdef BANK_LOADER_ERR_CNT_EN
    total++;
    if (err_count !== 8'd0) begin
      bad++;
      $display("FAIL mid_errcnt got %0d want 0", err_count);
    end
`endif
  endtask

  task automatic test_saturate();
    int wrong = 0;
    clear_q();
    bank_ready = 1'b1;
    for (int i = 0; i < 300; i++) send_line("x");
    drain();
    foreach (obs_errs[i]) if (obs_errs[i] !== 2'd1) wrong++;
    total++;
    if (obs_errs.size() != 300 || wrong != 0) begin
      bad++;
      $display("FAIL sat_errs got n=%0d wrong=%0d want 300 0", obs_errs.size(), wrong);
    end
`ifdef BANK_LOADER_ERR_CNT_EN
    total++;
    if (int'(err_count) != ((err_model > 255) ? 255 : err_model)) begin
      bad++;
      $display("FAIL sat_errcnt got %0d want %0d", err_count,
               (err_model > 255) ? 255 : err_model);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_random();
    test_midline_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bank_loader.md
# bank_loader

Front-end loader for the jolt-finding datapath. It accepts the puzzle input as a byte stream of ASCII characters, validates each line, packs the digits of one bank into a packed BCD word, and presents that word on a valid/ready output. The output word is exactly the `bcdIn` operand of the downstream max-jolt finder. It sits between the character source (UART RX or ROM reader) and the finder/accumulator chain.

## Interface
- `DIGITS`, default 5, number of BCD digits per bank line.
- `ERR_CNT_W`, default 8, width of the saturating error counter (used only with `BANK_LOADER_ERR_CNT_EN`).
- `clk`  in  1  Single clock; all logic rises on its posedge.
- `rst_n`  in  1  Reset, asynchronous assert, active-low.
- `ch_valid`  in  1  Input byte is valid.
- `ch_data`  in  8  ASCII character.
- `ch_ready`  out  1  Loader accepts a byte this cycle.
- `bank_valid`  out  1  `bank_data` holds a complete bank.
- `bank_data`  out  4*DIGITS  Packed BCD. The first character received sits in the top nibble `[4*DIGITS-1 -: 4]`.
- `bank_ready`  in  1  Consumer accepts `bank_data`.
- `err_pulse`  out  1  One-cycle strobe when a line is rejected.
- `err_code`  out  2  Reason for the rejection: 1 = illegal char, 2 = line too long, 3 = line too short. Held until the next error.
- `err_count`  out  ERR_CNT_W  Number of rejected lines (only with the macro).

## Operation
- States: COLLECT, HOLD, DISCARD. Reset state is COLLECT.
- A byte is accepted when `ch_valid && ch_ready` is true.
- `ch_ready` equals `state != HOLD` (combinational).
- Digit counter `cnt` has width `$clog2(DIGITS+1)`.

COLLECT, per accepted byte:
- `0x30..0x39`:
  - If `cnt < DIGITS`: shift left one nibble, insert `ch_data[3:0]` at the LSB nibble, `cnt++`.
  - Else: error 2, go to DISCARD.
- `0x0D`: ignored, no state change.
- `0x0A`:
  - If `cnt == DIGITS`: go to HOLD.
  - If `cnt == 0`: ignored (blank line).
  - Else: error 3, clear `cnt` and the shift register, stay in COLLECT.
- Any other byte: error 1, go to DISCARD.

DISCARD:
- Drop bytes until `0x0A` is accepted.
- Then clear `cnt` and go to COLLECT. No further error is raised for that line.

HOLD:
- `bank_valid` = 1. `bank_data` stays stable.
- On `bank_valid && bank_ready`: clear `cnt`, go to COLLECT.

Error rules:
- Each error raises `err_pulse` for exactly one cycle, in the cycle after the offending byte is accepted.
- `err_code` updates in that same cycle.

Reset:
- `rst_n` low mid-line or mid-HOLD discards all partial state immediately.
- State returns to COLLECT.

## Timing
Reset values of the outputs:
- `bank_valid` 0
- `bank_data` 0
- `err_pulse` 0
- `err_code` 0
- `err_count` 0
- `ch_ready` 1

Latency and throughput:
- Newline accepted at edge N gives `bank_valid` high from cycle N+1.
- With `bank_ready` held high, the handshake completes at edge N+1. `ch_ready` is high again from cycle N+2.
- Peak throughput is one byte per cycle, except for one stall cycle per bank.

Backpressure:
- With `bank_ready` low, HOLD persists indefinitely.
- `ch_ready` stays 0 throughout, so no byte is lost.

Simultaneous events:
- `ch_valid` is never sampled in HOLD, so a byte cannot collide with the output handshake.

## Configuration
- `BANK_LOADER_ERR_CNT_EN` defined: `err_count` port exists.
  - Increments on each `err_pulse`.
  - Saturates at all-ones (no wrap).
  - Cleared only by reset.
- Macro undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
Shared package `jolt_pkg` holds:
- `ASCII_LF`, `ASCII_CR`, `ASCII_0`, `ASCII_9` constants.
- The state enum `bank_ld_state_t`.
- The error-code enum `bank_err_t` (NONE=0, BADCHAR=1, LONG=2, SHORT=3).
- `BANK_DIGITS` = 5, shared with the finder.

No sub-module is needed. Digit classification is a local function, not a separate module.

## Test plan
- "98765\n", `bank_ready`=1 → one `bank_valid` cycle with `bank_data`=0x98765. No `err_pulse`.
- "12345\r\n" then "54321\n" with `bank_ready` low for 10 cycles → first word 0x12345 held stable for 10 cycles with `ch_ready`=0. Then 0x54321 appears.
- "12a45\n" then "11111\n" → `err_pulse` with `err_code`=1, no output for the bad line. Then 0x11111 is emitted.
- "123456\n" → `err_code`=2, nothing emitted. "123\n" → `err_code`=3, nothing emitted. "\n" alone → no output and no error.
- `rst_n` pulsed low after "987" then "11111\n" → only 0x11111 is emitted. With the macro on, `err_count` stays 0.
- 300 bad lines with the macro defined and `ERR_CNT_W`=8 → `err_count` = 255 (saturates).
